// File: rtl/bit5_serial_tx.sv
// bit5_serial_tx: 5-bit parallel-in, serial-out frame transmitter.
// Frame on Tx: start bit (0), 5 data bits LSB first, optional even-parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks. Every output is driven from a register.
// Next-state and next-output values are computed combinationally, then registered.
module bit5_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Din,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       Tx,
  output logic       done
);

  // The cycle counter needs at least one bit, so CLKS_PER_BIT=1 still gets a counter.
  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic [4:0]    shreg;
  logic [4:0]    shreg_nxt;
  logic          par;
  logic          par_nxt;
  logic          bit_end;

  logic          tx_nxt;
  logic          ready_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  // Even parity: the parity bit makes the total count of ones in data plus parity even.
  function automatic logic even_parity(input logic [4:0] word);
    return ^word;
  endfunction

  // Next-state logic: frame sequencing, bit timing, shift register and parity capture.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_nxt     = par;
    bit_end     = (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        // ready is high whenever the FSM is in IDLE, so load alone qualifies the accept.
        if (load) begin
          state_nxt   = START;
          shreg_nxt   = Din;
          par_nxt     = even_parity(Din);
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end
      end

      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          shreg_nxt = {1'b0, shreg[4:1]};
          if (bit_idx == BIT_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, so the registered outputs line up with the state.
  always_comb begin
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state == STOP) && (state_nxt == IDLE);

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // State, counter and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
    end
  end

  // Output registers; reset forces the idle line level immediately, without a done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Tx    <= 1'b1;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      Tx    <= tx_nxt;
      ready <= ready_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bit5_serial_tx.sv
// Bench for bit5_serial_tx: three instances with different timing and parity settings,
// checked cycle by cycle against a frame model built from the bit-level frame format.
`timescale 1ns/1ps
module tb_bit5_serial_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       clk_run = 1'b0;

  logic [4:0] din_a = '0, din_b = '0, din_c = '0;
  logic       load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;
  logic       ready_a, busy_a, tx_a, done_a;
  logic       ready_b, busy_b, tx_b, done_b;
  logic       ready_c, busy_c, tx_c, done_c;

  int total = 0;
  int bad   = 0;

  logic exp_tx [0:63];
  logic exp_busy [0:63];
  logic exp_ready [0:63];
  logic exp_done [0:63];
  int   exp_n;

  logic obs_tx [0:63];
  logic obs_busy [0:63];
  logic obs_ready [0:63];
  logic obs_done [0:63];

  bit5_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .CLK(CLK), .RST(RST), .Din(din_a), .load(load_a),
    .ready(ready_a), .busy(busy_a), .Tx(tx_a), .done(done_a)
  );

  bit5_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (
    .CLK(CLK), .RST(RST), .Din(din_b), .load(load_b),
    .ready(ready_b), .busy(busy_b), .Tx(tx_b), .done(done_b)
  );

  bit5_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut_c (
    .CLK(CLK), .RST(RST), .Din(din_c), .load(load_c),
    .ready(ready_c), .busy(busy_c), .Tx(tx_c), .done(done_c)
  );

  // Clock that can be held still so asynchronous reset is observable without edges.
  initial forever begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected per-cycle view of one frame, starting the cycle after the accept edge:
  // every bit repeated cpb times, then one done cycle, then one quiet idle cycle.
  function automatic void model(input logic [4:0] d, input int p, input int cpb);
    logic bits[$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 5; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (p != 0) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    exp_n = 0;
    foreach (bits[i]) begin
      for (int c = 0; c < cpb; c++) begin
        exp_tx[exp_n]    = bits[i];
        exp_busy[exp_n]  = 1'b1;
        exp_ready[exp_n] = 1'b0;
        exp_done[exp_n]  = 1'b0;
        exp_n++;
      end
    end
    exp_tx[exp_n] = 1'b1; exp_busy[exp_n] = 1'b0; exp_ready[exp_n] = 1'b1; exp_done[exp_n] = 1'b1;
    exp_n++;
    exp_tx[exp_n] = 1'b1; exp_busy[exp_n] = 1'b0; exp_ready[exp_n] = 1'b1; exp_done[exp_n] = 1'b0;
    exp_n++;
  endfunction

  // Load word d into instance sel, scramble Din after the accept, and record n cycles.
  // With inject_at >= 0 (instance a only) a second load of 5'b11111 is attempted mid-frame.
  task automatic collect(input int sel, input logic [4:0] d, input int n, input int inject_at);
    @(negedge CLK);
    case (sel)
      0: begin din_a = d; load_a = 1'b1; end
      1: begin din_b = d; load_b = 1'b1; end
      default: begin din_c = d; load_c = 1'b1; end
    endcase
    @(posedge CLK);
    #1;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    case (sel)
      0: din_a = ~d;
      1: din_b = ~d;
      default: din_c = ~d;
    endcase
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      case (sel)
        0: begin obs_tx[k] = tx_a; obs_busy[k] = busy_a; obs_ready[k] = ready_a; obs_done[k] = done_a; end
        1: begin obs_tx[k] = tx_b; obs_busy[k] = busy_b; obs_ready[k] = ready_b; obs_done[k] = done_b; end
        default: begin obs_tx[k] = tx_c; obs_busy[k] = busy_c; obs_ready[k] = ready_c; obs_done[k] = done_c; end
      endcase
      if (sel == 0 && k == inject_at) begin load_a = 1'b1; din_a = 5'b11111; end
      if (sel == 0 && k == inject_at + 8) load_a = 1'b0;
    end
  endtask

  task automatic test_reset();
    clk_run = 1'b0;
    #3 RST = 1'b1;
    #1;
    total++;
    if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      bad++; $display("FAIL reset_a got tx,ready,busy,done=%b%b%b%b want 1100", tx_a, ready_a, busy_a, done_a);
    end
    total++;
    if ({tx_b, ready_b, busy_b, done_b} !== 4'b1100) begin
      bad++; $display("FAIL reset_b got tx,ready,busy,done=%b%b%b%b want 1100", tx_b, ready_b, busy_b, done_b);
    end
    total++;
    if ({tx_c, ready_c, busy_c, done_c} !== 4'b1100) begin
      bad++; $display("FAIL reset_c got tx,ready,busy,done=%b%b%b%b want 1100", tx_c, ready_c, busy_c, done_c);
    end
    #2 RST = 1'b0;
    clk_run = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      bad++; $display("FAIL idle_after_reset got tx,ready,busy,done=%b%b%b%b want 1100", tx_a, ready_a, busy_a, done_a);
    end
  endtask

  task automatic test_single_frame();
    model(5'b10110, 1, 4);
    collect(0, 5'b10110, exp_n, -1);
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k]} !== {exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]}) begin
        bad++;
        $display("FAIL single_frame cycle=%0d got tx,busy,ready,done=%b%b%b%b want %b%b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k], exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]);
      end
    end
    total++;
    if (obs_done[31] !== 1'b0 || obs_done[32] !== 1'b1) begin
      bad++; $display("FAIL single_frame_done_at_32 got done[31]=%b done[32]=%b want 0 1", obs_done[31], obs_done[32]);
    end
  endtask

  task automatic test_parity();
    logic [4:0] words [0:2];
    logic       want [0:2];
    logic [4:0] d;
    words[0] = 5'b11110; want[0] = 1'b0;
    words[1] = 5'b00000; want[1] = 1'b0;
    words[2] = 5'b11111; want[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = (i < 3) ? words[i] : 5'($urandom_range(31, 0));
      model(d, 1, 4);
      collect(0, d, exp_n, -1);
      for (int k = 0; k < exp_n; k++) begin
        total++;
        if ({obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k]} !== {exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]}) begin
          bad++;
          $display("FAIL parity_frame din=%b cycle=%0d got tx,busy,ready,done=%b%b%b%b want %b%b%b%b", d, k,
                   obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k], exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]);
        end
      end
      if (i < 3) begin
        total++;
        if (obs_tx[25] !== want[i]) begin
          bad++; $display("FAIL parity_bit din=%b got %b want %b", d, obs_tx[25], want[i]);
        end
      end
    end
  endtask

  task automatic test_no_parity();
    logic [4:0] d;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 5'b00001 : 5'($urandom_range(31, 0));
      model(d, 0, 4);
      collect(1, d, exp_n, -1);
      for (int k = 0; k < exp_n; k++) begin
        total++;
        if ({obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k]} !== {exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]}) begin
          bad++;
          $display("FAIL no_parity din=%b cycle=%0d got tx,busy,ready,done=%b%b%b%b want %b%b%b%b", d, k,
                   obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k], exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]);
        end
      end
      total++;
      if (obs_done[27] !== 1'b0 || obs_done[28] !== 1'b1) begin
        bad++; $display("FAIL no_parity_done_at_28 got done[27]=%b done[28]=%b want 0 1", obs_done[27], obs_done[28]);
      end
    end
  endtask

  task automatic test_ignored_load();
    model(5'b01010, 1, 4);
    collect(0, 5'b01010, exp_n, 10);
    for (int k = 0; k < exp_n; k++) begin
      total++;
      if ({obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k]} !== {exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]}) begin
        bad++;
        $display("FAIL ignored_load cycle=%0d got tx,busy,ready,done=%b%b%b%b want %b%b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_ready[k], obs_done[k], exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      total++;
      if ({tx_a, busy_a, ready_a, done_a} !== 4'b1010) begin
        bad++; $display("FAIL no_second_frame cycle=%0d got tx,busy,ready,done=%b%b%b%b want 1010", k, tx_a, busy_a, ready_a, done_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] d [0:4];
    for (int f = 0; f < 5; f++) d[f] = 5'($urandom_range(31, 0));
    @(negedge CLK);
    din_c = d[0];
    load_c = 1'b1;
    @(posedge CLK);
    for (int f = 0; f < 5; f++) begin
      model(d[f], 1, 1);
      #1 din_c = ~d[f];
      for (int k = 0; k < 9; k++) begin
        @(negedge CLK);
        total++;
        if ({tx_c, busy_c, ready_c, done_c} !== {exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]}) begin
          bad++;
          $display("FAIL back_to_back frame=%0d cycle=%0d got tx,busy,ready,done=%b%b%b%b want %b%b%b%b", f, k,
                   tx_c, busy_c, ready_c, done_c, exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]);
        end
      end
      if (f < 4) din_c = d[f + 1];
      else load_c = 1'b0;
      @(posedge CLK);
    end
    @(negedge CLK);
    total++;
    if ({tx_c, busy_c, ready_c, done_c} !== 4'b1010) begin
      bad++; $display("FAIL stream_stop got tx,busy,ready,done=%b%b%b%b want 1010", tx_c, busy_c, ready_c, done_c);
    end
  endtask

  task automatic test_abort();
    logic [4:0] dn;
    @(negedge CLK);
    din_a = 5'b00011;
    load_a = 1'b1;
    @(posedge CLK);
    #1 load_a = 1'b0;
    // Cycles 12..15 after the accept carry data bit 2, which is 0 for this word.
    for (int k = 0; k < 14; k++) @(negedge CLK);
    total++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL abort_pre got tx=%b busy=%b want tx=0 busy=1", tx_a, busy_a);
    end
    #2 RST = 1'b1;
    #1;
    total++;
    if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      bad++; $display("FAIL abort_async got tx,ready,busy,done=%b%b%b%b want 1100", tx_a, ready_a, busy_a, done_a);
    end
    @(posedge CLK);
    #1;
    total++;
    if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin
      bad++; $display("FAIL abort_hold got tx,ready,busy,done=%b%b%b%b want 1100", tx_a, ready_a, busy_a, done_a);
    end
    dn = 5'($urandom_range(31, 0));
    model(dn, 1, 4);
    @(negedge CLK);
    RST = 1'b0;
    din_a = dn;
    load_a = 1'b1;
    @(posedge CLK);
    #1;
    load_a = 1'b0;
    din_a = ~dn;
    for (int k = 0; k < exp_n; k++) begin
      @(negedge CLK);
      total++;
      if ({tx_a, busy_a, ready_a, done_a} !== {exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]}) begin
        bad++;
        $display("FAIL after_abort din=%b cycle=%0d got tx,busy,ready,done=%b%b%b%b want %b%b%b%b", dn, k,
                 tx_a, busy_a, ready_a, done_a, exp_tx[k], exp_busy[k], exp_ready[k], exp_done[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_no_parity();
    test_ignored_load();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
